// File: rtl/two_src_arbiter_if.sv
// rtl/two_src_arbiter_if.sv - handshake bundle between two sources, the arbiter and one consumer
interface two_src_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master: the arbiter itself
  modport master (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data
  );

  // slave: the surrounding sources and consumer
  modport slave (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data
  );
endinterface

// File: rtl/two_src_arbiter.sv
// rtl/two_src_arbiter.sv - round-robin 2:1 arbiter feeding a one-entry registered output
module two_src_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  two_src_arbiter_if.master bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             last_grant_q, last_grant_d;

  logic grant_valid;
  logic grant_src;
  logic can_load;
  logic load;

  // On a tie the source that did not win last time gets the slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_A;
    if (bus.a_valid && !bus.b_valid) begin
      grant_valid = 1'b1;
      grant_src   = SRC_A;
    end else if (!bus.a_valid && bus.b_valid) begin
      grant_valid = 1'b1;
      grant_src   = SRC_B;
    end else if (bus.a_valid && bus.b_valid) begin
      grant_valid = 1'b1;
      grant_src   = ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;

    can_load = (state_q == EMPTY) || bus.out_ready;
    load     = grant_valid && can_load && !rst;

    if (load) begin
      state_d      = FULL;
      out_data_d   = (grant_src == SRC_B) ? bus.b_data : bus.a_data;
      last_grant_d = grant_src;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // Outputs are masked during reset so a held word is never reported as a transfer.
  always_comb begin
    bus.a_ready   = load && (grant_src == SRC_A);
    bus.b_ready   = load && (grant_src == SRC_B);
    bus.sel       = !rst && grant_valid && (grant_src == SRC_B);
    bus.out_valid = !rst && (state_q == FULL);
    bus.out_data  = rst ? '0 : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      last_grant_q <= SRC_B;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_two_src_arbiter.sv
// tb/tb_two_src_arbiter.sv - scoreboard bench for two_src_arbiter
module tb_two_src_arbiter;

  logic clk;
  logic rst;

  two_src_arbiter_if #(.WIDTH(8)) bus ();

  two_src_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic ordy);
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    rst = 1'b0;
  endtask

  // Monitor: every output transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (!rnd_mode) begin
        if (exp_q.size() == 0) chk("unexpected_out", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
        else chk("out_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end else if (bus.out_data[7]) begin
        if (qb.size() == 0) chk("rnd_unexpected_b", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
        else chk("rnd_b_order", {24'h0, bus.out_data}, {24'h0, qb.pop_front()});
      end else begin
        if (qa.size() == 0) chk("rnd_unexpected_a", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
        else chk("rnd_a_order", {24'h0, bus.out_data}, {24'h0, qa.pop_front()});
      end
    end
  end

  initial begin
    int a_cnt;
    int b_cnt;
    logic av, bv;
    logic [7:0] ad, bd;

    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 8'h98, 1'b1);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_a_ready", 32'(bus.a_ready), 0);
    chk("rst_b_ready", 32'(bus.b_ready), 0);
    chk("rst_sel", 32'(bus.sel), 0);

    // Single A word straight after reset.
    rst = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    chk("t1_a_ready", 32'(bus.a_ready), 1);
    chk("t1_b_ready", 32'(bus.b_ready), 0);
    chk("t1_sel", 32'(bus.sel), 0);
    exp_q.push_back(8'h11);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_data", 32'(bus.out_data), 32'h11);
    step();
    chk("t1_drained", 32'(bus.out_valid), 0);

    // Both sources continuously valid: strict alternation, no bubbles.
    do_reset();
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hB2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      drive(1'b1, 8'(8'hA0 + (k + 1) / 2), 1'b1, 8'(8'hB0 + k / 2), 1'b1);
      chk("t2_a_ready", 32'(bus.a_ready), 32'((k % 2) == 0));
      chk("t2_b_ready", 32'(bus.b_ready), 32'((k % 2) == 1));
      chk("t2_sel", 32'(bus.sel), 32'((k % 2) == 1));
      if (k > 0) chk("t2_no_bubble", 32'(bus.out_valid), 1);
    end
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t2_last_word", 32'(bus.out_data), 32'hB2);
    step();
    chk("t2_drained", 32'(bus.out_valid), 0);

    // Backpressure while FULL, then resume with no gap.
    drive(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    chk("t3_load_a_ready", 32'(bus.a_ready), 1);
    exp_q.push_back(8'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
      chk("t3_hold_valid", 32'(bus.out_valid), 1);
      chk("t3_hold_data", 32'(bus.out_data), 32'h22);
      chk("t3_hold_a_ready", 32'(bus.a_ready), 0);
      chk("t3_hold_b_ready", 32'(bus.b_ready), 0);
    end
    step();
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
    chk("t3_resume_b_ready", 32'(bus.b_ready), 1);
    chk("t3_resume_a_ready", 32'(bus.a_ready), 0);
    exp_q.push_back(8'h44);
    step();
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    chk("t3_next_valid", 32'(bus.out_valid), 1);
    chk("t3_next_data", 32'(bus.out_data), 32'h44);
    chk("t3_next_a_ready", 32'(bus.a_ready), 1);
    exp_q.push_back(8'h33);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t3_last_data", 32'(bus.out_data), 32'h33);

    // Only B valid.
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b0, 8'h00, 1'b1, 8'(k + 1), 1'b1);
      chk("t4_b_ready", 32'(bus.b_ready), 1);
      chk("t4_a_ready", 32'(bus.a_ready), 0);
      chk("t4_sel", 32'(bus.sel), 1);
      exp_q.push_back(8'(k + 1));
    end
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t4_last_data", 32'(bus.out_data), 32'h03);
    step();

    // Reset while FULL discards the held word; first tie afterwards goes to A.
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    chk("t5_load_a_ready", 32'(bus.a_ready), 1);
    step();
    rst = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    chk("t5_rst_a_ready", 32'(bus.a_ready), 0);
    chk("t5_rst_b_ready", 32'(bus.b_ready), 0);
    chk("t5_rst_sel", 32'(bus.sel), 0);
    chk("t5_rst_out_valid", 32'(bus.out_valid), 0);
    step();
    rst = 1'b0;
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    chk("t5_post_out_valid", 32'(bus.out_valid), 0);
    chk("t5_post_out_data", 32'(bus.out_data), 0);
    chk("t5_tie_a_ready", 32'(bus.a_ready), 1);
    chk("t5_tie_sel", 32'(bus.sel), 0);
    exp_q.push_back(8'h66);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t5_out_data", 32'(bus.out_data), 32'h66);
    step();
    chk("directed_queue_empty", 32'(exp_q.size()), 0);

    // Random valid/ready; A words tagged with bit7=0, B words with bit7=1.
    rnd_mode = 1'b1;
    a_cnt = 0;
    b_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      av = 1'($urandom_range(0, 1));
      bv = 1'($urandom_range(0, 1));
      ad = {1'b0, a_cnt[6:0]};
      bd = {1'b1, b_cnt[6:0]};
      drive(av, ad, bv, bd, 1'($urandom_range(0, 3) != 0));
      chk("rnd_mutex", 32'(bus.a_ready & bus.b_ready), 0);
      if (bus.a_ready) begin
        qa.push_back(ad);
        a_cnt++;
      end
      if (bus.b_ready) begin
        qb.push_back(bd);
        b_cnt++;
      end
    end
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    step();
    chk("rnd_qa_empty", 32'(qa.size()), 0);
    chk("rnd_qb_empty", 32'(qb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
